// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int         BCD_MAX   = 9999;
    localparam logic [3:0] DIG_BLANK = 4'hF;
    localparam int         NUM_DIG   = 4;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 to any nibble that is 5 or more.
module bcd_add3 (
    input  logic [3:0] in_nib,
    output logic [3:0] out_nib
);
    // Correct before the shift so the nibble cannot pass 9 after doubling.
    always_comb begin
        out_nib = (in_nib >= 4'd5) ? in_nib + 4'd3 : in_nib;
    end
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to 4-digit BCD converter with a
// start/busy/done handshake. Digits update together on the done cycle.
// Optional macro BCD_LEADING_BLANK_EN: leading zero digits become 4'hF.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       dig_0,
    output logic [3:0]       dig_1,
    output logic [3:0]       dig_2,
    output logic [3:0]       dig_3
);
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t                   state;
    logic [BIN_W-1:0]         bin_sr;
    logic [15:0]              scratch;
    logic [15:0]              corr;
    logic [CNT_W-1:0]         cnt;
    logic                     ovf_next;
    logic [NUM_DIG-1:0][3:0]  ld;
`ifdef BCD_LEADING_BLANK_EN
    logic                     lead;
`endif

    // One corrector per scratch nibble.
    for (genvar g = 0; g < NUM_DIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .in_nib  (scratch[4*g +: 4]),
            .out_nib (corr[4*g +: 4])
        );
    end

    // Digit values to publish at DONE: scratch, or saturated 9999 on overflow.
    always_comb begin
        ld = ovf_next ? {NUM_DIG{4'd9}} : scratch;
`ifdef BCD_LEADING_BLANK_EN
        lead = !ovf_next;
        for (int i = NUM_DIG - 1; i > 0; i--) begin
            if (lead && ld[i] == 4'd0) ld[i] = DIG_BLANK;
            else                       lead = 1'b0;
        end
`endif
    end

    // Conversion FSM; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bin_sr   <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_next <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            dig_0    <= '0;
            dig_1    <= '0;
            dig_2    <= '0;
            dig_3    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr   <= bin_in;
                        scratch  <= '0;
                        ovf_next <= ({{(32-BIN_W){1'b0}}, bin_in} > 32'(BCD_MAX));
                        cnt      <= CNT_W'(BIN_W);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Top scratch carry is dropped; overflowed values take the saturated path.
                    scratch <= (corr << 1) | 16'(bin_sr[BIN_W-1]);
                    bin_sr  <= bin_sr << 1;
                    cnt     <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= DONE;
                end
                DONE: begin
                    dig_0 <= ld[0];
                    dig_1 <= ld[1];
                    dig_2 <= ld[2];
                    dig_3 <= ld[3];
                    ovf   <= ovf_next;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed and random conversions
// against an arithmetic decimal model.
module tb_bin2bcd_seq;
    localparam int BIN_W = 14;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin_in = '0;
    logic             busy, done, ovf;
    logic [3:0]       dig_0, dig_1, dig_2, dig_3;

    int total = 0;
    int bad   = 0;

    bin2bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .dig_0  (dig_0),
        .dig_1  (dig_1),
        .dig_2  (dig_2),
        .dig_3  (dig_3)
    );

    always #5 clk = ~clk;

    // Decimal model: digits {d3,d2,d1,d0} of v, saturated above 9999.
    function automatic logic [15:0] model_dig(input int v);
        int d [4];
        logic [15:0] r;
        if (v > 9999) return 16'h9999;
        d[0] = v % 10;
        d[1] = (v / 10) % 10;
        d[2] = (v / 100) % 10;
        d[3] = v / 1000;
        r = {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
`ifdef BCD_LEADING_BLANK_EN
        for (int i = 3; i > 0; i--) begin
            if (d[i] != 0) break;
            r[4*i +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full conversion from IDLE; random start pulses and bin_in churn
    // while busy must not disturb the result.
    task automatic do_conv(input int v, input bit noise);
        logic [BIN_W-1:0] vv;
        int               val;
        logic [15:0]      hold;
        vv  = BIN_W'(v);
        val = int'(vv);
        bin_in = vv;
        start  = 1'b1;
        step();                                   // edge 0: accepted
        start = 1'b0;
        for (int k = 1; k <= BIN_W + 1; k++) begin
            chk("busy_in_flight", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            if (noise) begin
                bin_in = BIN_W'($urandom);
                start  = 1'($urandom_range(0, 1));
            end
            if (k == BIN_W + 1) start = 1'b0;
            step();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("digits", 32'({dig_3, dig_2, dig_1, dig_0}), 32'(model_dig(val)));
        chk("ovf", 32'(ovf), 32'(val > 9999));
        hold = {dig_3, dig_2, dig_1, dig_0};
        step();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("digits_hold", 32'({dig_3, dig_2, dig_1, dig_0}), 32'(hold));
    endtask

    initial begin
        // Reset state.
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_digits", 32'({dig_3, dig_2, dig_1, dig_0}), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Directed values, including the overflow boundary.
        do_conv(0, 1'b0);
        do_conv(1234, 1'b0);
        do_conv(9999, 1'b0);
        do_conv(10000, 1'b0);
        do_conv(16383, 1'b0);
        do_conv(7, 1'b0);
        do_conv(4000, 1'b1);
        do_conv(42, 1'b1);

        // Random values with start/bin_in noise while busy.
        for (int n = 0; n < 40; n++) begin
            do_conv(int'($urandom_range(0, (1 << BIN_W) - 1)), 1'b1);
        end
        do_conv(5678, 1'b0);

        // Reset mid-conversion discards the in-flight value.
        bin_in = BIN_W'(321);
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 8; k++) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_digits", 32'({dig_3, dig_2, dig_1, dig_0}), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", 32'(busy), 32'd0);
        do_conv(321, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential shift-add-3 (double-dabble) converter that turns a binary count into four BCD digits.
- Sits directly upstream of the display digit multiplexer and drives its dig_0..dig_3 inputs.
- Digit outputs are registered and update atomically, once per completed conversion, so the refresh scan never shows a half-converted value.
- Start/busy/done handshake; one conversion in flight at a time.

Parameters:
- BIN_W, 14, width of binary input; legal range 4..16; 14 covers 0..16383.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a conversion of bin_in; sampled only in IDLE.
- bin_in  input  BIN_W  binary value; captured on the accepted start edge only.
- busy  output  1  high while state is not IDLE.
- done  output  1  one-cycle pulse; digits valid and updated on this cycle.
- ovf  output  1  registered; high when the last captured value exceeded 9999.
- dig_0  output  4  BCD units digit.
- dig_1  output  4  BCD tens digit.
- dig_2  output  4  BCD hundreds digit.
- dig_3  output  4  BCD thousands digit.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE.
  - busy, done, ovf = 0.
  - dig_0..dig_3 = 0.
  - Internal shift registers and iteration counter = 0.
- States and transitions:
  - IDLE: if start = 1, capture bin_in into the shift register and clear the 16-bit BCD scratch. Set ovf_next = (bin_in > 9999); this is always 0 when BIN_W < 14. Load counter = BIN_W and go to SHIFT.
  - SHIFT: each cycle, apply add-3 correction to every scratch nibble >= 5, then shift {scratch, binary} left by 1 and decrement the counter. After BIN_W SHIFT cycles, go to DONE.
  - DONE: assert done for exactly one cycle.
    - Load dig_3..dig_0 from scratch, or from 9,9,9,9 when ovf_next = 1.
    - Load ovf from ovf_next.
    - Return to IDLE.
- Latency: start sampled at edge 0; done is high during the cycle following edge BIN_W+1 (15 cycles for BIN_W = 14). Outputs change only at that edge.
- start while busy (SHIFT or DONE) is ignored; there is no queuing. The earliest next accepted start is the first IDLE cycle after done.
- bin_in changes after capture have no effect on the conversion in flight.
- Scratch arithmetic: the final scratch result must never exceed 4 bits per nibble. Values > 9999 use the saturated output path, so the scratch is 16 bits wide and truncation of the top carry is permitted.
- Overflow: digits saturate to 9999 and ovf stays high until the next completed conversion clears or sets it.
- Reset mid-conversion aborts the conversion; outputs take their reset values and the in-flight value is discarded.
- Between conversions, dig_* hold their last value indefinitely.

Optional Feature:
- Macro: BCD_LEADING_BLANK_EN.
- Defined: at the DONE load, leading zero digits are replaced by blank code 4'hF, scanning from dig_3 downward. dig_0 is never blanked; value 0 shows only dig_0 = 0. Saturated 9999 is unaffected. The downstream decoder renders 4'hF as all segments off.
- Undefined: digits are always plain BCD with leading zeros, e.g. 42 -> 0,0,4,2.

Decomposition:
- Shared package bcd_pkg holds:
  - state typedef (IDLE, SHIFT, DONE).
  - BCD_MAX = 9999.
  - DIG_BLANK = 4'hF.
  - NUM_DIG = 4.
- One natural sub-module: bcd_add3, a combinational nibble corrector (in >= 5 ? in + 3 : in). It is instantiated four times on the scratch register.

Test Plan:
- Reset then bin_in = 0, start pulse -> done at cycle 15; dig_3..dig_0 = 0,0,0,0; ovf = 0; busy high for cycles 1..15.
- bin_in = 1234, start -> dig_3..dig_0 = 1,2,3,4 at done. Then bin_in = 9999 -> 9,9,9,9 with ovf = 0.
- bin_in = 10000, then 16383 -> both give 9,9,9,9 with ovf = 1. A following conversion of 7 clears ovf and gives 0,0,0,7 (0xF,0xF,0xF,7 with BCD_LEADING_BLANK_EN).
- Start 0x0FA0 (4000), then pulse start again at cycle 5 with bin_in = 1 -> second start ignored; done only once, at cycle 15, with digits 4,0,0,0. Change bin_in at cycle 3 -> result unaffected.
- Converting 5678 completes, then a new conversion of 321 is started and rst_n is pulsed low at cycle 8 -> immediately dig_* = 0, busy = 0, done = 0. After release, a fresh start with 321 gives 0,3,2,1.
- BIN_W = 8 build: bin_in = 255 -> 0,2,5,5 at cycle 9; ovf never asserts.
